trigger_delay_ctrl: RTL and testbench
=====================================

TRIGGER_DELAY_CTRL -- requirements
Module: trigger_delay_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, sets the delay-count width; it SHALL match the controlled delay line's address width.
REQ-002 Parameter LATENCY, default 2, gives the delay line's fixed pipeline cycles (address register plus RAM read); it SHALL be added to every drain and flush count.
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be rising-edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port cfg_delay, input, WIDTH: requested delay in cycles; 0 selects bypass.
REQ-006 Port cfg_valid / cfg_ready, input / output, 1 each: valid/ready handshake for cfg_delay.
REQ-007 Port flush_req, input, 1: single-cycle pulse that clears scheduled triggers without changing the delay.
REQ-008 Port trig_in, input, 1: raw trigger from upstream.
REQ-009 Port enable, input, 1: gates trig_in into the delay line.
REQ-010 Ports dl_delay (output, WIDTH), dl_d (output, 1) and dl_q (input, 1): drive the delay line's delay and d ports and receive its q.
REQ-011 Port trig_out, output, 1: delayed trigger after blanking.
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port state_o, output, 2: encoding IDLE=0, DRAIN=1, FLUSH=2.

Function
REQ-014 The FSM SHALL have three states: IDLE, DRAIN and FLUSH.
REQ-015 In IDLE:
- cfg_ready=1
- dl_d = trig_in & enable
- trig_out = dl_q
- dl_delay = active delay register
REQ-016 When cfg_valid & cfg_ready, the block SHALL latch cfg_delay into the pending register and go to DRAIN, with cnt = active + LATENCY.
REQ-017 On flush_req in IDLE, the block SHALL set pending = active and go to DRAIN with the same count as REQ-016.
REQ-018 If cfg_valid and flush_req arrive in the same IDLE cycle, the block SHALL accept the configuration and handle only one sequence.
REQ-019 A flush_req arriving outside IDLE SHALL be ignored.
REQ-020 cfg_ready SHALL be 0 outside IDLE, so no configuration is accepted there.
REQ-021 In DRAIN:
- dl_d = 0
- dl_delay = active
- trig_out = dl_q, so already-scheduled triggers still emerge
- cnt decrements each cycle
REQ-022 When DRAIN reaches cnt==0, the block SHALL set active = pending and go to FLUSH with cnt = pending + LATENCY.
REQ-023 In FLUSH:
- dl_d = 0
- dl_delay = active
- trig_out = 0, blanking stale RAM contents
- cnt decrements each cycle
REQ-024 When FLUSH reaches cnt==0, the block SHALL return to IDLE; normal gating SHALL resume on the next cycle.
REQ-025 cnt SHALL be WIDTH+1 bits wide, so a delay of 2^WIDTH-1 plus LATENCY cannot overflow.
REQ-026 With a delay of 0, DRAIN and FLUSH SHALL each still last LATENCY+1 cycles.
REQ-027 Total busy time per sequence SHALL be (old+LATENCY+1) + (new+LATENCY+1) cycles.
REQ-028 trig_in pulses seen while busy SHALL be discarded and SHALL NOT be queued.
REQ-029 dl_d and trig_out SHALL be combinational from state and inputs; all other outputs SHALL be registered.

Reset
REQ-030 While rst_n=0, the block SHALL hold state=IDLE, active=0, pending=0 and cnt=0.
REQ-031 During reset, the outputs SHALL be:
- dl_delay = 0 (delay-line bypass)
- busy = 0
- cfg_ready = 1
REQ-032 Reset asserted mid-DRAIN or mid-FLUSH SHALL abort the sequence immediately, with no completion cycle.
REQ-033 After reset, the first operation SHALL be a flush_req, because the RAM contents are unknown.

Configuration
REQ-034 With TRIG_DELAY_CTRL_DROP_CNT_EN defined, the block SHALL add output drop_cnt (16 bits, saturating at 0xFFFF):
- increments on each rising edge of trig_in seen while busy
- clears on reset
REQ-035 Without TRIG_DELAY_CTRL_DROP_CNT_EN, drop_cnt and its logic SHALL be absent.

Verification
REQ-036 Reset, then flush_req; cfg 5, then trig_in pulse at cycle T: trig_out pulses exactly at T+5+LATENCY offset as the delay line defines, and busy=0 during the pulse.
REQ-037 Active delay 10, schedule a trigger, then cfg 3 two cycles later:
- the old trigger still appears during DRAIN
- DRAIN lasts 13 cycles and FLUSH lasts 6 cycles
- no spurious trig_out during FLUSH
REQ-038 cfg_valid held high during DRAIN: cfg_ready=0, the value is not accepted, and it is accepted on the first IDLE cycle.
REQ-039 cfg_valid and flush_req in the same cycle with cfg 7: exactly one DRAIN→FLUSH sequence runs, and active ends at 7.
REQ-040 rst_n pulsed low mid-FLUSH: state_o=0, dl_delay=0, busy=0 asynchronously.
REQ-041 With the macro defined, 3 trig_in pulses during busy give drop_cnt=3; 70000 pulses give drop_cnt=0xFFFF.

Source files
------------

// File: rtl/trigger_delay_ctrl.sv
// Trigger delay-line controller: drains scheduled triggers, then flushes stale RAM, around every delay change.
// Latency: dl_d/trig_out are combinational; cfg/flush take effect on the next clock, busy for (old+LAT+1)+(new+LAT+1) cycles.
// Backpressure: cfg_ready is low while busy; flush_req outside IDLE and trig_in pulses while busy are dropped.
// Optional: define TRIG_DELAY_CTRL_DROP_CNT_EN to add a saturating 16-bit drop_cnt of trig_in rising edges lost while busy.
module trigger_delay_ctrl #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] cfg_delay,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             flush_req,
   input  logic             trig_in,
   input  logic             enable,
   output logic [WIDTH-1:0] dl_delay,
   output logic             dl_d,
   input  logic             dl_q,
   output logic             trig_out,
   output logic             busy,
   output logic [1:0]       state_o
`ifdef TRIG_DELAY_CTRL_DROP_CNT_EN
   ,
   output logic [15:0]      drop_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // One extra bit so the largest delay plus pipeline latency still fits.
   localparam logic [WIDTH:0] LAT_W   = (WIDTH+1)'(LATENCY);
   localparam logic [WIDTH:0] CNT_ONE = (WIDTH+1)'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH:0]   cnt_q, cnt_d;
   logic             busy_q, cfg_ready_q;

   // Next-state logic: a cfg handshake wins over a simultaneous flush, both start one drain/flush sequence.
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               pending_d = cfg_delay;
               state_d   = DRAIN;
               cnt_d     = {1'b0, active_q} + LAT_W;
            end else if (flush_req) begin
               pending_d = active_q;
               state_d   = DRAIN;
               cnt_d     = {1'b0, active_q} + LAT_W;
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               active_d = pending_q;
               state_d  = FLUSH;
               cnt_d    = {1'b0, pending_q} + LAT_W;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, delay registers and registered status flags; reset leaves the delay line in bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         active_q    <= '0;
         pending_q   <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         busy_q      <= (state_d != IDLE);
         cfg_ready_q <= (state_d == IDLE);
      end
   end

   // Triggers enter the line only in IDLE; output is blanked while stale RAM contents are being flushed.
   always_comb begin
      dl_d     = (state_q == IDLE) & trig_in & enable;
      trig_out = (state_q != FLUSH) & dl_q;
   end

   assign dl_delay  = active_q;
   assign busy      = busy_q;
   assign cfg_ready = cfg_ready_q;
   assign state_o   = state_q;

`ifdef TRIG_DELAY_CTRL_DROP_CNT_EN
   logic        trig_prev_q;
   logic [15:0] drop_cnt_q;

   // Count rising edges of trig_in lost while busy, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_prev_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         trig_prev_q <= trig_in;
         if ((state_q != IDLE) && trig_in && !trig_prev_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_trigger_delay_ctrl.sv
// Bench for trigger_delay_ctrl: timeline model of drain/flush windows plus a history-based delay line.
// Inputs are driven 2 time units after the rising edge; outputs are checked on the falling edge.
// Directed scenarios pin the model with hand-computed phase lengths and trigger arrival times.
module tb_trigger_delay_ctrl;

   localparam int W   = 16;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  cfg_delay = '0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic          flush_req = 1'b0;
   logic          trig_in = 1'b0;
   logic          enable = 1'b0;
   logic [W-1:0]  dl_delay;
   logic          dl_d;
   logic          dl_q;
   logic          trig_out;
   logic          busy;
   logic [1:0]    state_o;
`ifdef TRIG_DELAY_CTRL_DROP_CNT_EN
   logic [15:0]   drop_cnt;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   trigger_delay_ctrl #(.WIDTH(W), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_delay(cfg_delay), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .flush_req(flush_req), .trig_in(trig_in), .enable(enable),
      .dl_delay(dl_delay), .dl_d(dl_d), .dl_q(dl_q), .trig_out(trig_out),
      .busy(busy), .state_o(state_o)
`ifdef TRIG_DELAY_CTRL_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Delay line: q is d from (delay + LAT) cycles ago; dl_force injects junk while flushing.
   logic [63:0] hist = '0;
   logic        dl_force = 1'b0;
   always @(posedge clk) hist <= {hist[62:0], dl_d};
   always_comb begin
      int idx;
      idx  = int'(dl_delay) + LAT - 1;
      dl_q = (dl_force && state_o == 2'd2);
      if (idx >= 0 && idx < 64) dl_q = dl_q | hist[idx];
   end

   // Model: each accepted request fixes absolute cycle windows [start, drain_end) DRAIN, [drain_end, flush_end) FLUSH.
   int cyc = 0;
   int m_drain_end = 0, m_flush_end = 0;
   int m_old = 0, m_new = 0;
   int m_drop = 0;
   logic m_tprev = 1'b0;

   function automatic int phase(input int n);
      if (n < m_drain_end) return 1;
      if (n < m_flush_end) return 2;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_drain_end = 0; m_flush_end = 0; m_old = 0; m_new = 0; m_drop = 0; m_tprev = 1'b0;
      end else begin
         int p;
         p = phase(cyc);
         if (p == 0 && (cfg_valid || flush_req)) begin
            m_old = m_new;
            if (cfg_valid) m_new = int'(cfg_delay);
            m_drain_end = cyc + 1 + m_old + LAT + 1;
            m_flush_end = m_drain_end + m_new + LAT + 1;
         end
         if (p != 0 && trig_in && !m_tprev && m_drop < 65535) m_drop++;
         m_tprev = trig_in;
         cyc++;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_state", state_o, 0);
         chk("rst_dl_delay", dl_delay, 0);
         chk("rst_busy", busy, 0);
         chk("rst_cfg_ready", cfg_ready, 1);
      end else begin
         int p;
         int edly;
         p    = phase(cyc);
         edly = (cyc >= m_drain_end) ? m_new : m_old;
         chk("state_o", state_o, p);
         chk("busy", busy, (p != 0));
         chk("cfg_ready", cfg_ready, (p == 0));
         chk("dl_delay", dl_delay, edly);
         chk("dl_d", dl_d, (p == 0) && trig_in && enable);
         chk("trig_out", trig_out, dl_q && (p != 2));
`ifdef TRIG_DELAY_CTRL_DROP_CNT_EN
         chk("drop_cnt", drop_cnt, m_drop);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Count DRAIN/FLUSH cycles (and trig_out pulses in each) of one sequence; returns in the first IDLE cycle.
   task automatic measure(output int d, output int f, output int td, output int tf);
      bit done;
      d = 0; f = 0; td = 0; tf = 0; done = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (state_o == 2'd1) begin
            d++; td += int'(trig_out);
         end else if (state_o == 2'd2) begin
            f++; tf += int'(trig_out);
         end else if (d + f > 0) begin
            done = 1;
            break;
         end
      end
      if (!done) chk("measure_timeout", 1, 0);
   endtask

   initial begin
      int d, f, td, tf, hit, busy_at;
      bit found;

      repeat (3) @(negedge clk);
      chk("reset_state_lit", state_o, 0);
      chk("reset_dl_delay_lit", dl_delay, 0);
      chk("reset_busy_lit", busy, 0);
      chk("reset_cfg_ready_lit", cfg_ready, 1);
      tick(); rst_n = 1'b1; tick();

      // Initial flush with delay 0: 3 + 3 cycles.
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      measure(d, f, td, tf);
      chk("s1_flush_drain", d, 3);
      chk("s1_flush_flush", f, 3);

      // cfg 5 from 0: drain 3, flush 8.
      tick(); cfg_valid = 1'b1; cfg_delay = 16'd5; tick(); cfg_valid = 1'b0;
      measure(d, f, td, tf);
      chk("s1_cfg5_drain", d, 3);
      chk("s1_cfg5_flush", f, 8);

      // Trigger at cycle T must emerge at T + 5 + LAT.
      tick(); enable = 1'b1; tick(); trig_in = 1'b1; tick(); trig_in = 1'b0;
      hit = 0; busy_at = 1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (trig_out && hit == 0) begin
            hit = k; busy_at = int'(busy);
         end
      end
      chk("s1_trig_offset", hit, 7);
      chk("s1_busy_at_pulse", busy_at, 0);

      // Move to delay 10: drain 8, flush 13.
      tick(); cfg_valid = 1'b1; cfg_delay = 16'd10; tick(); cfg_valid = 1'b0;
      measure(d, f, td, tf);
      chk("s2_cfg10_drain", d, 8);
      chk("s2_cfg10_flush", f, 13);

      // Schedule a trigger, reconfigure to 3 two cycles later; junk is injected on dl_q while flushing.
      tick(); trig_in = 1'b1; tick(); trig_in = 1'b0; tick();
      cfg_valid = 1'b1; cfg_delay = 16'd3; dl_force = 1'b1; tick(); cfg_valid = 1'b0;
      measure(d, f, td, tf);
      dl_force = 1'b0;
      chk("s2_drain_len", d, 13);
      chk("s2_flush_len", f, 6);
      chk("s2_old_trig_in_drain", td, 1);
      chk("s2_trig_in_flush", tf, 0);

      // Flush, then hold cfg 4 valid through the sequence; accepted on the first IDLE cycle.
      tick(); flush_req = 1'b1; tick(); flush_req = 1'b0; cfg_valid = 1'b1; cfg_delay = 16'd4;
      measure(d, f, td, tf);
      chk("s3_flush_drain", d, 6);
      chk("s3_flush_flush", f, 6);
      chk("s3_idle_cfg_ready", cfg_ready, 1);
      tick(); cfg_valid = 1'b0;
      fork
         measure(d, f, td, tf);
         begin
            repeat (2) tick();
            flush_req = 1'b1; tick(); flush_req = 1'b0;
            repeat (3) begin
               trig_in = 1'b1; tick(); trig_in = 1'b0; tick();
            end
         end
      join
      chk("s3_cfg4_drain", d, 6);
      chk("s3_cfg4_flush", f, 7);
`ifdef TRIG_DELAY_CTRL_DROP_CNT_EN
      chk("s3_drop_cnt", drop_cnt, 3);
`endif
      repeat (3) @(negedge clk);
      chk("s3_stays_idle", state_o, 0);

      // cfg_valid and flush_req together with cfg 7: one sequence, active ends at 7.
      tick(); cfg_valid = 1'b1; flush_req = 1'b1; cfg_delay = 16'd7; tick();
      cfg_valid = 1'b0; flush_req = 1'b0;
      measure(d, f, td, tf);
      chk("s4_drain", d, 7);
      chk("s4_flush", f, 10);
      repeat (5) @(negedge clk);
      chk("s4_single_seq", state_o, 0);
      chk("s4_active", dl_delay, 7);

      // Asynchronous reset in the middle of FLUSH.
      tick(); flush_req = 1'b1; tick(); flush_req = 1'b0;
      found = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (state_o == 2'd2) begin
            found = 1;
            break;
         end
      end
      chk("s5_reach_flush", found, 1);
      tick(); rst_n = 1'b0; #1;
      chk("s5_async_state", state_o, 0);
      chk("s5_async_dl_delay", dl_delay, 0);
      chk("s5_async_busy", busy, 0);
      chk("s5_async_cfg_ready", cfg_ready, 1);
      tick(); rst_n = 1'b1; tick();
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      measure(d, f, td, tf);
      chk("s5_post_rst_drain", d, 3);
      chk("s5_post_rst_flush", f, 3);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
